// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter.
//   ps2_tx_state_t - transmitter FSM states
//   *_FALL         - device clock fall numbers within a host-to-device frame
//   CMD_*          - common keyboard command bytes
//   odd_parity()   - parity bit that makes the 9-bit data+parity word odd
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      BITS,
      WAIT_IDLE
   } ps2_tx_state_t;

   localparam logic [3:0] N_FRAME_FALLS = 4'd11;
   localparam logic [3:0] PARITY_FALL   = 4'd9;
   localparam logic [3:0] STOP_FALL     = 4'd10;
   localparam logic [3:0] ACK_FALL      = 4'd11;

   localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
   localparam logic [7:0] CMD_RESET     = 8'hFF;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between the top level and ps2_host_tx.
//   tx_valid/tx_data - command request (master drives)
//   tx_ready         - transmitter idle; transfer on tx_valid && tx_ready
//   tx_done/tx_error - one-cycle completion pulses
//   busy             - transmit in progress
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       busy;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_done, tx_error, busy
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_done, tx_error, busy
   );
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 line.
//   clk, rst - system clock, async active-high reset
//   pin      - raw asynchronous pin level
//   level    - synchronized, glitch-filtered level (resets to 1)
//   fall     - one-cycle pulse when level goes 1 -> 0
// The level changes only after FILTER_LEN consecutive synchronized samples
// disagree with it; pin-to-fall latency is 2 + FILTER_LEN cycles.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic fall
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] run_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         run_cnt <= '0;
         level   <= 1'b1;
         fall    <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         fall  <= 1'b0;
         if (sync2 == level) begin
            run_cnt <= '0;
         end else if (run_cnt == RUN_LAST) begin
            // FILTER_LEN-th disagreeing sample: commit the new level
            level   <= sync2;
            fall    <= level;
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//   clk, rst     - system clock, async active-high reset
//   tx           - command handshake (slave side): tx_valid, tx_data,
//                  tx_ready, tx_done, tx_error, busy
//   ps2_clk_in   - raw PS/2 clock pin
//   ps2_data_in  - raw PS/2 data pin
//   ps2_clk_oe   - 1 pulls PS/2 clock low
//   ps2_data_oe  - 1 pulls PS/2 data low
// Frame: inhibit clock, assert start bit, then drive data/parity/stop on
// device clock falls 1..10 and sample the device ACK on fall 11.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 2600,
   parameter int unsigned TIMEOUT_CYCLES = 500000,
   parameter int unsigned FILTER_LEN     = 4
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  tx,
   input  logic          ps2_clk_in,
   input  logic          ps2_data_in,
   output logic          ps2_clk_oe,
   output logic          ps2_data_oe
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES);

   logic clk_lvl, clk_fall;
   logic data_lvl, data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (ps2_clk_in),
      .level (clk_lvl),
      .fall  (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (ps2_data_in),
      .level (data_lvl),
      .fall  (data_fall_unused)
   );

   ps2_tx_state_t state_q, state_d;
   logic [7:0]    shifter_q, shifter_d;
   logic          parity_q, parity_d;
   logic [IW-1:0] inh_q, inh_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [3:0]    n_q, n_d;
   logic          data_oe_q, data_oe_d;
   logic          nack_q, nack_d;

   logic done, err, inh_last, release_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shifter_q <= '0;
         parity_q  <= 1'b0;
         inh_q     <= '0;
         wd_q      <= '0;
         n_q       <= '0;
         data_oe_q <= 1'b0;
         nack_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shifter_q <= shifter_d;
         parity_q  <= parity_d;
         inh_q     <= inh_d;
         wd_q      <= wd_d;
         n_q       <= n_d;
         data_oe_q <= data_oe_d;
         nack_q    <= nack_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shifter_d   = shifter_q;
      parity_d    = parity_q;
      inh_d       = inh_q;
      wd_d        = wd_q;
      n_d         = n_q;
      data_oe_d   = data_oe_q;
      nack_d      = nack_q;
      done        = 1'b0;
      err         = 1'b0;
      inh_last    = 1'b0;
      release_now = 1'b0;

      unique case (state_q)
         IDLE: begin
            data_oe_d = 1'b0;
            if (tx.tx_valid) begin
               shifter_d = tx.tx_data;
               parity_d  = odd_parity(tx.tx_data);
               inh_d     = '0;
               state_d   = INHIBIT;
            end
         end

         INHIBIT: begin
            if (inh_q == INH_LAST) begin
               // start bit goes out on the last inhibit cycle
               inh_last  = 1'b1;
               data_oe_d = 1'b1;
               wd_d      = '0;
               n_d       = '0;
               state_d   = START;
            end else begin
               inh_d = inh_q + 1'b1;
            end
         end

         START, BITS: begin
            // n_q counts falls already seen; the cycle after fall 11 resolves ACK
            if (state_q == BITS && n_q == N_FRAME_FALLS) begin
               if (nack_q) begin
                  err       = 1'b1;
                  data_oe_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  wd_d    = wd_q + 1'b1;
                  state_d = WAIT_IDLE;
               end
            end else if (clk_fall) begin
               wd_d    = '0;
               n_d     = n_q + 1'b1;
               state_d = BITS;
               if (n_q < PARITY_FALL - 4'd1) begin
                  data_oe_d = ~shifter_q[0];
                  shifter_d = shifter_q >> 1;
               end else if (n_q == PARITY_FALL - 4'd1) begin
                  data_oe_d = ~parity_q;
               end else if (n_q == STOP_FALL - 4'd1) begin
                  data_oe_d = 1'b0;
               end else begin
                  nack_d = data_lvl;
               end
            end else if (wd_q == WD_MAX) begin
               err         = 1'b1;
               release_now = 1'b1;
               data_oe_d   = 1'b0;
               state_d     = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         WAIT_IDLE: begin
            if (clk_lvl && data_lvl) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (wd_q == WD_MAX) begin
               err         = 1'b1;
               release_now = 1'b1;
               data_oe_d   = 1'b0;
               state_d     = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         default: begin
            data_oe_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   assign tx.tx_ready = (state_q == IDLE);
   assign tx.busy     = (state_q != IDLE);
   assign tx.tx_done  = done;
   assign tx.tx_error = err;
   assign ps2_clk_oe  = (state_q == INHIBIT);
   assign ps2_data_oe = (data_oe_q & ~release_now) | inh_last;

endmodule
